// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared state type and constants for the Viterbi frame controller
package viterbi_pkg;
  typedef enum logic [1:0] {FILL, DRAIN, TB, OUT} vit_ctrl_state_t;
  localparam int VIT_FRAME_LEN_DEF = 16;
  localparam int VIT_PM_W = 8;
  // Path metrics loaded on acs_clear: state 0 starts at zero, every other state at max
  localparam logic [VIT_PM_W-1:0] VIT_PM_INIT_ZERO = '0;
  localparam logic [VIT_PM_W-1:0] VIT_PM_INIT_MAX = '1;
endpackage

// File: rtl/viterbi_out_buf.sv
// viterbi_out_buf: FRAME_LEN x 1 reorder buffer, written in traceback order, read oldest-first
module viterbi_out_buf
  import viterbi_pkg::*;
#(
  parameter int DEPTH = VIT_FRAME_LEN_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);
  logic [DEPTH-1:0] mem;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer for the rate-1/2 hard-decision Viterbi decoder
// (symbol intake, ACS stepping, survivor traceback and oldest-first bit output)
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = VIT_FRAME_LEN_DEF,
  parameter int AW = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sym_valid,
  input  logic [1:0]    sym_pair,
  output logic          sym_ready,
  output logic [1:0]    bm_pair,
  output logic          acs_en,
  output logic          acs_clear,
  output logic          surv_we,
  output logic [AW-1:0] surv_addr,
  output logic          tb_start,
  output logic          tb_en,
  input  logic          tb_bit,
  output logic          out_valid,
  output logic          out_bit,
  input  logic          out_ready,
  output logic          frame_done
);
  localparam int TW = $clog2(FRAME_LEN + 1);
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TB_LAST = TW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TB_END = TW'(FRAME_LEN);
  vit_ctrl_state_t state, state_nx;
  logic [AW-1:0] k, j, addr_d, surv_addr_nx;
  logic [TW-1:0] tb_cnt;
  logic accept, out_take, cap, buf_bit;
  logic acs_en_nx, acs_clear_nx, tb_start_nx, tb_en_nx, out_valid_nx;
  assign sym_ready = state == FILL;
  assign accept = sym_valid & sym_ready;
  assign out_take = out_valid & out_ready;
  assign frame_done = out_take & (j == LAST);
  assign out_bit = out_valid & buf_bit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      FILL:    state_nx = (accept && k == LAST) ? DRAIN : FILL;
      DRAIN:   state_nx = TB;
      TB:      state_nx = (tb_cnt == TB_END) ? OUT : TB;
      OUT:     state_nx = frame_done ? FILL : OUT;
      default: state_nx = FILL;
    endcase
  end
  // Next values of the registered outputs; traceback runs FRAME_LEN steps plus one capture cycle
  always_comb begin
    acs_en_nx = accept;
    acs_clear_nx = accept & (k == '0);
    tb_start_nx = state == DRAIN;
    tb_en_nx = (state == DRAIN) || (state == TB && tb_cnt < TB_LAST);
    out_valid_nx = (state == TB && tb_cnt == TB_END) || (state == OUT && !frame_done);
    surv_addr_nx = accept ? k :
                   (state == DRAIN) ? LAST :
                   (state == TB && surv_addr != '0) ? surv_addr - AW'(1) : surv_addr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k <= '0;
      j <= '0;
      tb_cnt <= '0;
      bm_pair <= '0;
      acs_en <= 1'b0;
      acs_clear <= 1'b0;
      surv_we <= 1'b0;
      surv_addr <= '0;
      tb_start <= 1'b0;
      tb_en <= 1'b0;
      out_valid <= 1'b0;
      cap <= 1'b0;
      addr_d <= '0;
    end else begin
      acs_en <= acs_en_nx;
      surv_we <= acs_en_nx;
      acs_clear <= acs_clear_nx;
      surv_addr <= surv_addr_nx;
      tb_start <= tb_start_nx;
      tb_en <= tb_en_nx;
      out_valid <= out_valid_nx;
      cap <= tb_en;
      addr_d <= surv_addr;
      if (accept) bm_pair <= sym_pair;
      k <= accept ? ((k == LAST) ? k : k + AW'(1)) : frame_done ? '0 : k;
      tb_cnt <= (state == DRAIN) ? '0 : (state == TB && tb_cnt != TB_END) ? tb_cnt + TW'(1) : tb_cnt;
      j <= frame_done ? '0 : out_take ? j + AW'(1) : j;
    end
  viterbi_out_buf #(.DEPTH(FRAME_LEN), .AW(AW)) u_out_buf (
    .clk(clk),
    .rst_n(rst_n),
    .we(cap),
    .waddr(addr_d),
    .wdata(tb_bit),
    .raddr(j),
    .rdata(buf_bit)
  );
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: scoreboard bench for the Viterbi frame controller (FRAME_LEN 4 and 5)
module tb_viterbi_frame_ctrl;
  localparam int N = 4;
  localparam int M = 5;
  logic clk = 1'b0;
  logic rst_n;
  logic sym_valid, sym_ready, acs_en, acs_clear, surv_we, tb_start, tb_en, tb_bit;
  logic out_valid, out_bit, out_ready, frame_done;
  logic [1:0] sym_pair, bm_pair, surv_addr;
  logic b_sym_valid, b_sym_ready, b_acs_en, b_acs_clear, b_surv_we, b_tb_start, b_tb_en, b_tb_bit;
  logic b_out_valid, b_out_bit, b_out_ready, b_frame_done;
  logic [1:0] b_sym_pair, b_bm_pair;
  logic [2:0] b_surv_addr;
  int vectors = 0;
  int errors = 0;
  logic [4:0] acs_q[$];
  logic [1:0] out_q[$];
  logic [5:0] b_acs_q[$];
  logic [1:0] b_out_q[$];
  logic [N-1:0] tbm;
  logic [M-1:0] tbm5;
  logic acc_prev, ov_prev, tbp_en, b_acc_prev, b_tbp_en;
  logic [1:0] tbp_addr;
  logic [2:0] b_tbp_addr;
  int model_k, b_model_k, tb_exp, tb_seen;

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.FRAME_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_pair(sym_pair), .sym_ready(sym_ready),
    .bm_pair(bm_pair), .acs_en(acs_en), .acs_clear(acs_clear), .surv_we(surv_we), .surv_addr(surv_addr),
    .tb_start(tb_start), .tb_en(tb_en), .tb_bit(tb_bit), .out_valid(out_valid), .out_bit(out_bit),
    .out_ready(out_ready), .frame_done(frame_done)
  );

  viterbi_frame_ctrl #(.FRAME_LEN(M)) dut5 (
    .clk(clk), .rst_n(rst_n), .sym_valid(b_sym_valid), .sym_pair(b_sym_pair), .sym_ready(b_sym_ready),
    .bm_pair(b_bm_pair), .acs_en(b_acs_en), .acs_clear(b_acs_clear), .surv_we(b_surv_we), .surv_addr(b_surv_addr),
    .tb_start(b_tb_start), .tb_en(b_tb_en), .tb_bit(b_tb_bit), .out_valid(b_out_valid), .out_bit(b_out_bit),
    .out_ready(b_out_ready), .frame_done(b_frame_done)
  );

  // FRAME_LEN=4 monitor: ACS scoreboard, traceback sequence, traceback-unit model, output scoreboard
  always @(negedge clk) begin
    logic [4:0] e;
    logic [1:0] o;
    if (!rst_n) begin
      acs_q.delete(); out_q.delete();
      acc_prev = 0; ov_prev = 0; tbp_en = 0; tbp_addr = 0; tb_bit = 0;
      model_k = 0; tb_exp = 0; tb_seen = 0;
    end else begin
      vectors++;
      if (acs_en !== acc_prev) begin
        errors++; $display("FAIL acs_latency: acs_en=%b want %b", acs_en, acc_prev);
      end
      if (acs_en === 1'b1) begin
        vectors++;
        if (acs_q.size() == 0) begin
          errors++; $display("FAIL acs_extra: unexpected acs_en addr=%0d", surv_addr);
        end else begin
          e = acs_q.pop_front();
          if ({surv_we, surv_addr, acs_clear, bm_pair} !== {1'b1, e}) begin
            errors++; $display("FAIL acs_step: we/addr/clr/pair=%b want %b", {surv_we, surv_addr, acs_clear, bm_pair}, {1'b1, e});
          end
        end
      end
      acc_prev = sym_valid & sym_ready;
      if (acc_prev) begin
        acs_q.push_back({2'(model_k), model_k == 0, sym_pair});
        model_k = (model_k + 1) % N;
      end
      if (tb_start === 1'b1) begin
        vectors++;
        if (tb_en !== 1'b1 || surv_addr !== 2'(N - 1)) begin
          errors++; $display("FAIL tb_start: tb_en=%b addr=%0d want 1 %0d", tb_en, surv_addr, N - 1);
        end
        tb_exp = N - 2; tb_seen = 1;
      end else if (tb_en === 1'b1) begin
        vectors++;
        if (int'(surv_addr) != tb_exp) begin
          errors++; $display("FAIL tb_addr: addr=%0d want %0d", surv_addr, tb_exp);
        end
        tb_exp--; tb_seen++;
      end
      if (out_valid === 1'b1 && !ov_prev) begin
        vectors++;
        if (tb_seen != N) begin
          errors++; $display("FAIL tb_steps: %0d tb_en cycles want %0d", tb_seen, N);
        end
        tb_seen = 0;
      end
      ov_prev = out_valid;
      tb_bit = tbp_en ? tbm[tbp_addr] : 1'b0;
      tbp_en = tb_en; tbp_addr = surv_addr;
      vectors++;
      if (out_valid === 1'b1 && out_ready) begin
        if (out_q.size() == 0) begin
          errors++; $display("FAIL out_extra: unexpected bit %b", out_bit);
        end else begin
          o = out_q.pop_front();
          if ({out_bit, frame_done} !== {o[0], o[1]}) begin
            errors++; $display("FAIL out_bit: bit/done=%b%b want %b%b", out_bit, frame_done, o[0], o[1]);
          end
        end
      end else if (frame_done !== 1'b0) begin
        errors++; $display("FAIL frame_done_idle: frame_done=%b want 0", frame_done);
      end
    end
  end

  // FRAME_LEN=5 monitor: ACS and output scoreboards plus traceback-unit model
  always @(negedge clk) begin
    logic [5:0] e;
    logic [1:0] o;
    if (!rst_n) begin
      b_acs_q.delete(); b_out_q.delete();
      b_acc_prev = 0; b_tbp_en = 0; b_tbp_addr = 0; b_tb_bit = 0; b_model_k = 0;
    end else begin
      vectors++;
      if (b_acs_en !== b_acc_prev) begin
        errors++; $display("FAIL b2b_acs_latency: acs_en=%b want %b", b_acs_en, b_acc_prev);
      end
      if (b_acs_en === 1'b1) begin
        vectors++;
        if (b_acs_q.size() == 0) begin
          errors++; $display("FAIL b2b_acs_extra: unexpected acs_en addr=%0d", b_surv_addr);
        end else begin
          e = b_acs_q.pop_front();
          if ({b_surv_we, b_surv_addr, b_acs_clear, b_bm_pair} !== {1'b1, e}) begin
            errors++; $display("FAIL b2b_acs_step: got %b want %b", {b_surv_we, b_surv_addr, b_acs_clear, b_bm_pair}, {1'b1, e});
          end
        end
      end
      b_acc_prev = b_sym_valid & b_sym_ready;
      if (b_acc_prev) begin
        b_acs_q.push_back({3'(b_model_k), b_model_k == 0, b_sym_pair});
        b_model_k = (b_model_k + 1) % M;
      end
      b_tb_bit = b_tbp_en ? tbm5[b_tbp_addr] : 1'b0;
      b_tbp_en = b_tb_en; b_tbp_addr = b_surv_addr;
      if (b_out_valid === 1'b1 && b_out_ready) begin
        vectors++;
        if (b_out_q.size() == 0) begin
          errors++; $display("FAIL b2b_out_extra: unexpected bit %b", b_out_bit);
        end else begin
          o = b_out_q.pop_front();
          if ({b_out_bit, b_frame_done} !== {o[0], o[1]}) begin
            errors++; $display("FAIL b2b_out_bit: bit/done=%b%b want %b%b", b_out_bit, b_frame_done, o[0], o[1]);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (sym_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (sym_ready !== 1'b1) begin
      errors++; $display("FAIL wait_ready: sym_ready=%b want 1 after %0d cycles", sym_ready, n);
    end
  endtask

  task automatic drive_sym(input logic [1:0] p);
    int n = 0;
    logic ok = 1'b0;
    sym_valid = 1'b1; sym_pair = p;
    while (!ok && n < 200) begin
      @(negedge clk); ok = sym_ready;
      @(posedge clk); #1; n++;
    end
    sym_valid = 1'b0;
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL drive_sym: accepted=%b want 1", ok);
    end
  endtask

  task automatic load_frame(input logic [N-1:0] bits);
    wait_ready();
    tbm = bits;
    for (int i = 0; i < N; i++) out_q.push_back({i == N - 1, bits[i]});
  endtask

  task automatic send_frame(input logic [2*N-1:0] pairs, input logic [N-1:0] bits);
    load_frame(bits);
    for (int i = 0; i < N; i++) drive_sym(pairs[2*i +: 2]);
  endtask

  task automatic drain();
    int n = 0;
    while (out_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (out_q.size() != 0) begin
      errors++; $display("FAIL drain: %0d bits outstanding want 0", out_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sym_valid = 0; sym_pair = 0; out_ready = 1;
    b_sym_valid = 0; b_sym_pair = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if ({acs_en, acs_clear, surv_we, tb_start, tb_en, out_valid, frame_done, out_bit} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl: %b want 00000000", {acs_en, acs_clear, surv_we, tb_start, tb_en, out_valid, frame_done, out_bit});
    end
    if (bm_pair !== 2'b00) begin
      errors++; $display("FAIL reset_bm_pair: %b want 00", bm_pair);
    end
    if (surv_addr !== 2'd0) begin
      errors++; $display("FAIL reset_surv_addr: %0d want 0", surv_addr);
    end
    if (sym_ready !== 1'b1) begin
      errors++; $display("FAIL reset_sym_ready: %b want 1", sym_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_continuous();
    send_frame({2'b01, 2'b00, 2'b10, 2'b11}, 4'b1011);
    vectors++;
    if ({acs_en, surv_addr, sym_ready} !== {1'b1, 2'd3, 1'b0}) begin
      errors++; $display("FAIL cont_drain: en/addr/ready=%b want 1110", {acs_en, surv_addr, sym_ready});
    end
    drain();
    vectors++;
    if ({sym_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL cont_idle: ready/valid=%b want 10", {sym_ready, out_valid});
    end
  endtask

  task automatic test_reorder();
    for (int f = 0; f < 3; f++) begin
      send_frame(8'($urandom), 4'($urandom));
      drain();
    end
  endtask

  task automatic test_gaps();
    logic [6:0] pat = 7'b1011001;
    load_frame(4'($urandom));
    for (int i = 0; i < 7; i++) begin
      sym_valid = pat[i]; sym_pair = 2'($urandom);
      @(posedge clk); #1;
    end
    sym_valid = 1'b0;
    vectors++;
    if ({acs_en, surv_addr, sym_ready} !== {1'b1, 2'd3, 1'b0}) begin
      errors++; $display("FAIL gaps_last: en/addr/ready=%b want 1110", {acs_en, surv_addr, sym_ready});
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] bits = 4'b0110;
    int n = 0;
    send_frame(8'($urandom), bits);
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_bit, sym_ready} !== {1'b1, bits[1], 1'b0}) begin
        errors++; $display("FAIL bp_hold: valid/bit/ready=%b want %b", {out_valid, out_bit, sym_ready}, {1'b1, bits[1], 1'b0});
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    vectors++;
    if (sym_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: sym_ready=%b want 1", sym_ready);
    end
  endtask

  task automatic test_mid_reset();
    wait_ready();
    drive_sym(2'b10);
    drive_sym(2'b01);
    rst_n = 1'b0;
    #1;
    vectors += 2;
    if ({acs_en, acs_clear, surv_we, tb_start, tb_en, out_valid, frame_done} !== 7'b0) begin
      errors++; $display("FAIL midrst_ctrl: %b want 0000000", {acs_en, acs_clear, surv_we, tb_start, tb_en, out_valid, frame_done});
    end
    if ({bm_pair, surv_addr} !== 4'b0) begin
      errors++; $display("FAIL midrst_regs: pair/addr=%b want 0000", {bm_pair, surv_addr});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame({2'b11, 2'b01, 2'b00, 2'b10}, 4'b1101);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] fa = 5'b10110;
    logic [M-1:0] fb = 5'b01101;
    int n = 0, acc = 0, dones = 0;
    tbm5 = fa;
    for (int i = 0; i < M; i++) b_out_q.push_back({i == M - 1, fa[i]});
    for (int i = 0; i < M; i++) b_out_q.push_back({i == M - 1, fb[i]});
    b_sym_valid = 1'b1; b_sym_pair = 2'($urandom);
    while (dones < 2 && n < 300) begin
      logic done_now;
      @(negedge clk);
      if (b_sym_valid && b_sym_ready) acc++;
      done_now = b_frame_done;
      @(posedge clk); #1; n++;
      b_sym_pair = 2'($urandom);
      if (acc == 2 * M) b_sym_valid = 1'b0;
      if (done_now === 1'b1) begin
        dones++;
        if (dones == 1) begin
          tbm5 = fb;
          vectors++;
          if (b_sym_ready !== 1'b1 || acc != M) begin
            errors++; $display("FAIL b2b_restart: ready=%b accepts=%0d want 1 %0d", b_sym_ready, acc, M);
          end
        end
      end
    end
    b_sym_valid = 1'b0;
    vectors += 2;
    if (dones != 2 || acc != 2 * M) begin
      errors++; $display("FAIL b2b_count: frames=%0d accepts=%0d want 2 %0d", dones, acc, 2 * M);
    end
    if (b_out_q.size() != 0) begin
      errors++; $display("FAIL b2b_left: %0d bits outstanding want 0", b_out_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous();
    test_reorder();
    test_gaps();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
